// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : video_timing_gen
//  Description : Free-running raster timing source. Horizontal and vertical
//                counters are decoded into registered href/vref/de/hsync/
//                vsync/sof strobes. Each active cycle carries one 8-bit pixel.
//                The pixel is either pulled from upstream through pix_rdy or
//                generated internally.
//                Optional feature macro: VTG_PATTERN_EN. When it is defined,
//                data_out carries the (h_cnt + v_cnt) test pattern, pix_rdy
//                is held at 0, and pix_in is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen #(
  parameter int IMG_COL = 1920,
  parameter int IMG_ROW = 1080,
  parameter int H_FP    = 88,
  parameter int H_SYNC  = 44,
  parameter int H_BP    = 148,
  parameter int V_FP    = 4,
  parameter int V_SYNC  = 5,
  parameter int V_BP    = 36
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       en,
  input  logic [7:0] pix_in,
  output logic       pix_rdy,
  output logic       de,
  output logic       href,
  output logic       vref,
  output logic       hsync,
  output logic       vsync,
  output logic       sof,
  output logic [7:0] data_out
);

  localparam int H_TOT = IMG_COL + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = IMG_ROW + V_FP + V_SYNC + V_BP;

  // Region boundaries as 12-bit counter values (END values are exclusive).
  localparam logic [11:0] H_ACT_END  = 12'(IMG_COL);
  localparam logic [11:0] H_SYNC_BEG = 12'(IMG_COL + H_FP);
  localparam logic [11:0] H_SYNC_END = 12'(IMG_COL + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST     = 12'(H_TOT - 1);
  localparam logic [11:0] V_ACT_END  = 12'(IMG_ROW);
  localparam logic [11:0] V_SYNC_BEG = 12'(IMG_ROW + V_FP);
  localparam logic [11:0] V_SYNC_END = 12'(IMG_ROW + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST     = 12'(V_TOT - 1);

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;

  logic        h_act;
  logic        v_act;
  logic        h_in_sync;
  logic        v_in_sync;
  logic        h_wrap;
  logic        v_wrap;
  logic        frame_start;
  logic        pix_act;
  logic [7:0]  pix_sel;

  // Decode the current counter position into region flags.
  always_comb begin
    h_act       = (h_cnt < H_ACT_END);
    v_act       = (v_cnt < V_ACT_END);
    h_in_sync   = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
    v_in_sync   = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
    h_wrap      = (h_cnt == H_LAST);
    v_wrap      = (v_cnt == V_LAST);
    frame_start = (h_cnt == 12'd0) && (v_cnt == 12'd0);
    pix_act     = h_act && v_act;
  end

`ifdef VTG_PATTERN_EN
  // The pattern is the low byte of h+v, so only the low counter bytes matter.
  logic unused_pix_in;

  assign unused_pix_in = ^pix_in;
  assign pix_rdy       = 1'b0;

  // Internal test pattern replaces the upstream pixel.
  always_comb begin
    pix_sel = h_cnt[7:0] + v_cnt[7:0];
  end
`else
  // Request is gated by reset so that it reads 0 while the block is held in
  // reset, and goes high as soon as reset is released at frame start.
  assign pix_rdy = nrst && en && pix_act;

  // Upstream pixel passes straight through to the output register.
  always_comb begin
    pix_sel = pix_in;
  end
`endif

  // Raster counters: h wraps at end of line, v advances only on h wrap.
  // Dropping en clears both, so a restart always begins at frame start.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      h_cnt <= 12'd0;
      v_cnt <= 12'd0;
    end else if (!en) begin
      h_cnt <= 12'd0;
      v_cnt <= 12'd0;
    end else if (h_wrap) begin
      h_cnt <= 12'd0;
      v_cnt <= v_wrap ? 12'd0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  // Output registers: one cycle behind the counter state; all zero when idle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      href     <= 1'b0;
      vref     <= 1'b0;
      de       <= 1'b0;
      hsync    <= 1'b0;
      vsync    <= 1'b0;
      sof      <= 1'b0;
      data_out <= 8'd0;
    end else if (!en) begin
      href     <= 1'b0;
      vref     <= 1'b0;
      de       <= 1'b0;
      hsync    <= 1'b0;
      vsync    <= 1'b0;
      sof      <= 1'b0;
      data_out <= 8'd0;
    end else begin
      href     <= h_act;
      vref     <= v_act;
      de       <= pix_act;
      hsync    <= h_in_sync;
      vsync    <= v_in_sync;
      sof      <= frame_start;
      data_out <= pix_act ? pix_sel : 8'd0;
    end
  end

endmodule
`default_nettype wire

// File: doc/video_timing_gen.md
# video_timing_gen

Raster timing source for the denoising pipeline; it is the transmitter for the `de/href/vref/hsync/vsync/data_in` interface consumed by the block-extraction front end. It runs free-running horizontal and vertical counters, decodes them into registered sync and active-region strobes, and emits one 8-bit pixel per active cycle. Pixels come either from an upstream source through a `pix_rdy` pull handshake or from a built-in test pattern. It drives the front end in simulation benches and in FPGA bring-up.

## Interface
- `IMG_COL`, 1920, active pixels per line
- `IMG_ROW`, 1080, active lines per frame
- `H_FP` / `H_SYNC` / `H_BP`, 88 / 44 / 148, horizontal front porch, sync and back porch in cycles; H_TOT = IMG_COL+H_FP+H_SYNC+H_BP ≤ 4096
- `V_FP` / `V_SYNC` / `V_BP`, 4 / 5 / 36, vertical porches and sync in lines; V_TOT = IMG_ROW+V_FP+V_SYNC+V_BP ≤ 4096
- `clk`  in  1  single clock; all logic on the rising edge
- `nrst`  in  1  asynchronous, active-low reset
- `en`  in  1  run enable
- `pix_in`  in  8  upstream pixel, sampled on edges where `pix_rdy`=1
- `pix_rdy`  out  1  request: the upstream must present the next pixel this cycle
- `de`  out  1  active pixel strobe (`href & vref`)
- `href`  out  1  active column region
- `vref`  out  1  active row region
- `hsync`  out  1  horizontal sync, active high
- `vsync`  out  1  vertical sync, active high, line-aligned
- `sof`  out  1  one-cycle pulse coincident with the first `de` of each frame
- `data_out`  out  8  pixel, valid when `de`=1, otherwise 0

## Operation
- Counters `h_cnt`, `v_cnt` are 12 bit. `h_cnt` wraps at H_TOT-1 to 0. `v_cnt` increments only on that wrap and wraps at V_TOT-1 to 0.
- Line layout (`h_cnt`):
  - active: 0..IMG_COL-1
  - front porch: next H_FP cycles
  - sync: next H_SYNC cycles
  - back porch: remaining cycles
- The frame layout on `v_cnt` follows the same order.
- Decode from the current counters, registered one cycle:
  - `href` = h active
  - `vref` = v active
  - `de` = href & vref
  - `hsync` = h in sync
  - `vsync` = v in sync, for whole lines
  - `sof` = (h=0 & v=0)
- `pix_rdy` is combinational: (h active & v active & en).
- `data_out` is the `pix_in` registered on that same edge, forced to 0 when not active.
- `href` also toggles during vertical blanking lines; `de` does not.
- `en`=0: on the next edge both counters clear to 0 and every output register is loaded with 0. `pix_rdy`=0 immediately. Restarting with `en`=1 always begins at frame start (h=0, v=0).
- Reset mid-frame: all outputs go to 0 asynchronously and counters clear. No partial-line completion.
- Upstream cannot stall. A missing pixel is the upstream's fault, and `data_out` reflects whatever `pix_in` carries.

## Timing
- Reset value of every output is 0.
- Counters hold (0,0) during reset.
- First edge after `nrst` rises with `en`=1:
  - counters were (0,0) and `pix_rdy` was 1 before this edge
  - on this edge the output registers load `de`=`href`=`vref`=`sof`=1 and `data_out`=`pix_in`
  - on this edge the counters advance to (1,0)
- Output latency is 1 cycle from the counter state. `pix_in` reaches `data_out` in 1 cycle.
- `pix_rdy` leads `de` by exactly one cycle, for IMG_COL×IMG_ROW cycles per frame.
- `hsync` rises IMG_COL+H_FP cycles after `href` rises and stays high H_SYNC cycles.
- Frame period is H_TOT×V_TOT cycles. `sof` has exactly this period.
- `en` falling and the counter wrap on the same edge: clear wins.

## Configuration
- `VTG_PATTERN_EN` defined:
  - `data_out` = registered (h_cnt + v_cnt)[7:0] during active cycles, 0 otherwise
  - `pix_rdy` is tied to 0 and `pix_in` is ignored
- `VTG_PATTERN_EN` not defined: pull mode as described in Operation.

## Test plan
Bench parameters: IMG_COL=8, IMG_ROW=4, H_FP=H_SYNC=H_BP=2, V_FP=V_SYNC=V_BP=1, giving H_TOT=14, V_TOT=7 and a frame of 98 cycles.
- Release reset with `en`=1 and `pix_in` incrementing on each `pix_rdy`:
  - `sof` on cycle 1, then every 98 cycles
  - 32 `de` cycles per frame
  - `data_out` sequence equals the accepted `pix_in` sequence
- Horizontal: `href` high 8 cycles, low 6. `hsync` high on line cycles 10–11 only.
- Vertical: `vsync` high for all 14 cycles of line 5 only. Zero `de` on lines 4–6.
- Mid-line effects:
  - drop `en` at h=3, v=1 → next cycle all outputs 0
  - raise `en` 5 cycles later → next `de` carries `sof`
- Reset mid-frame: assert `nrst`=0 asynchronously at h=5, v=2 → all outputs 0 immediately. After release, behaviour is identical to the first test.
- With `VTG_PATTERN_EN`: frame-1 `data_out` at (h=7, v=3) = 10. `pix_rdy` constant 0.
